// File: rtl/kypd_pkg.sv
// Shared definitions for the PMOD keypad emulator: active-low matrix codes,
// key-to-position mapping and FSM state encoding.
package kypd_pkg;

    localparam logic [3:0] COL0 = 4'b0111;
    localparam logic [3:0] COL1 = 4'b1011;
    localparam logic [3:0] COL2 = 4'b1101;
    localparam logic [3:0] COL3 = 4'b1110;

    localparam logic [3:0] ROW0 = 4'b0111;
    localparam logic [3:0] ROW1 = 4'b1011;
    localparam logic [3:0] ROW2 = 4'b1101;
    localparam logic [3:0] ROW3 = 4'b1110;

    localparam logic [3:0] ROW_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP
    } kypd_state_e;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } kypd_pos_t;

    // Physical PMOD layout: columns 1-2-3-A, rows top to bottom.
    function automatic kypd_pos_t key_to_pos(input logic [3:0] key);
        kypd_pos_t p;
        case (key)
            4'h1: p = '{col: COL0, row: ROW0};
            4'h4: p = '{col: COL0, row: ROW1};
            4'h7: p = '{col: COL0, row: ROW2};
            4'h0: p = '{col: COL0, row: ROW3};
            4'h2: p = '{col: COL1, row: ROW0};
            4'h5: p = '{col: COL1, row: ROW1};
            4'h8: p = '{col: COL1, row: ROW2};
            4'hF: p = '{col: COL1, row: ROW3};
            4'h3: p = '{col: COL2, row: ROW0};
            4'h6: p = '{col: COL2, row: ROW1};
            4'h9: p = '{col: COL2, row: ROW2};
            4'hE: p = '{col: COL2, row: ROW3};
            4'hA: p = '{col: COL3, row: ROW0};
            4'hB: p = '{col: COL3, row: ROW1};
            4'hC: p = '{col: COL3, row: ROW2};
            default: p = '{col: COL3, row: ROW3}; // key D
        endcase
        return p;
    endfunction

endpackage

// File: rtl/kypd_key_fifo.sv
// Small synchronous FIFO buffering queued key codes; DEPTH must be a power of two.
module kypd_key_fifo
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/kypd_emulator.sv
// PMOD 4x4 keypad emulator: replays queued key codes as timed presses by
// answering the scanner's column strobes on the Row lines.
module kypd_emulator
    import kypd_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int FIFO_DEPTH  = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       pressed,
    output logic       busy
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    kypd_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    cur_key_q;
    logic          pressed_q;
    logic [3:0]    row_q;
    logic [3:0]    row_d;
    kypd_pos_t     cur_pos;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [3:0]    fifo_data;

    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    kypd_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (4)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (key_valid),
        .data_i  (key_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_key_q <= '0;
            pressed_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_key_q <= fifo_data;
                        cnt_q     <= HOLD_LOAD;
                        pressed_q <= 1'b1;
                        state_q   <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (cnt_q == '0) begin
                        cnt_q     <= GAP_LOAD;
                        pressed_q <= 1'b0;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    // Only an exact single-column strobe matching the held key gets a response.
    always_comb begin
        cur_pos = key_to_pos(cur_key_q);
        row_d   = ROW_NONE;
        if ((state_q == ST_PRESS) && (Col == cur_pos.col)) begin
            row_d = cur_pos.row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= ROW_NONE;
        end else begin
            row_q <= row_d;
        end
    end

    assign Row       = row_q;
    assign pressed   = pressed_q;
    assign key_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_kypd_emulator.sv
// Directed bench for kypd_emulator with short hold/gap timing.
module tb_kypd_emulator;
    localparam int H = 20;
    localparam int G = 10;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Col;
    logic [3:0] Row;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic       pressed;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kypd_emulator #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Col       (Col),
        .Row       (Row),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .pressed   (pressed),
        .busy      (busy)
    );

    // Hand-written keypad layout: {col, row}, both active-low.
    function automatic logic [7:0] exp_map(input logic [3:0] k);
        case (k)
            4'h1: return 8'b0111_0111;
            4'h4: return 8'b0111_1011;
            4'h7: return 8'b0111_1101;
            4'h0: return 8'b0111_1110;
            4'h2: return 8'b1011_0111;
            4'h5: return 8'b1011_1011;
            4'h8: return 8'b1011_1101;
            4'hF: return 8'b1011_1110;
            4'h3: return 8'b1101_0111;
            4'h6: return 8'b1101_1011;
            4'h9: return 8'b1101_1101;
            4'hE: return 8'b1101_1110;
            4'hA: return 8'b1110_0111;
            4'hB: return 8'b1110_1011;
            4'hC: return 8'b1110_1101;
            default: return 8'b1110_1110;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pressed(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pressed === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_released(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pressed === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [3:0] cols [4];
        cols[0] = 4'b0111; cols[1] = 4'b1011; cols[2] = 4'b1101; cols[3] = 4'b1110;
        rst = 1'b1; key_valid = 1'b0; key_in = 4'h0; Col = 4'hF;
        tick(); tick();
        rst = 1'b0;
        tick();
        total_cnt++; if (Row !== 4'hF) $display("FAIL reset_row got=%b exp=1111", Row); else pass_cnt++;
        total_cnt++; if (key_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", key_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (pressed !== 1'b0) $display("FAIL reset_pressed got=%b exp=0", pressed); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            Col = cols[i];
            tick(); tick();
            total_cnt++;
            if (Row !== 4'hF) $display("FAIL idle_sweep col=%b got=%b exp=1111", cols[i], Row);
            else pass_cnt++;
        end
        Col = 4'hF;
    endtask

    task automatic test_single_key();
        int pc, rl, bad, seen;
        bit ok;
        Col = 4'b1011; key_in = 4'h5; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        total_cnt++;
        if (pressed !== 1'b0 || busy !== 1'b1 || Row !== 4'hF)
            $display("FAIL single_t1 pressed=%b busy=%b row=%b exp 0/1/1111", pressed, busy, Row);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pressed !== 1'b1 || Row !== 4'hF)
            $display("FAIL single_t2 pressed=%b row=%b exp 1/1111", pressed, Row);
        else pass_cnt++;
        pc = 1; rl = 0; bad = 0;
        for (int i = 3; i <= 40; i++) begin
            tick();
            if (i == 3) begin
                total_cnt++;
                if (Row !== 4'b1011) $display("FAIL single_t3_row got=%b exp=1011", Row); else pass_cnt++;
            end
            if (i == 23) begin
                total_cnt++;
                if (Row !== 4'hF) $display("FAIL single_release_row got=%b exp=1111", Row); else pass_cnt++;
            end
            if (pressed === 1'b1) pc++;
            if (Row === 4'b1011) rl++;
            else if (Row !== 4'hF) bad++;
        end
        total_cnt++; if (pc != H) $display("FAIL single_pressed_len got=%0d exp=%0d", pc, H); else pass_cnt++;
        total_cnt++; if (rl != H) $display("FAIL single_row_len got=%0d exp=%0d", rl, H); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL single_row_glitch got=%0d exp=0", bad); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_done_busy got=%b exp=0", busy); else pass_cnt++;

        // Same key with the wrong column strobed must never answer.
        Col = 4'b0111; key_in = 4'h5; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        seen = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pressed === 1'b1) seen++;
            if (Row !== 4'hF) bad++;
        end
        total_cnt++; if (seen != H) $display("FAIL wrongcol_pressed_len got=%0d exp=%0d", seen, H); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL wrongcol_row got=%0d bad cycles exp=0", bad); else pass_cnt++;
        wait_idle(ok);
        total_cnt++; if (!ok) $display("FAIL single_idle_timeout busy=%b exp=0", busy); else pass_cnt++;
        Col = 4'hF;
    endtask

    task automatic test_all_keys();
        logic [7:0] m;
        logic [3:0] k;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            m = exp_map(k);
            key_in = k; key_valid = 1'b1;
            tick();
            key_valid = 1'b0;
            wait_pressed(ok);
            Col = m[7:4];
            tick(); tick();
            total_cnt++;
            if (!ok || Row !== m[3:0])
                $display("FAIL key_%h_row pressed_ok=%0d got=%b exp=%b", k, ok, Row, m[3:0]);
            else pass_cnt++;
            Col = {m[6:4], m[7]};
            tick(); tick();
            total_cnt++;
            if (Row !== 4'hF) $display("FAIL key_%h_othercol got=%b exp=1111", k, Row); else pass_cnt++;
            Col = 4'hF;
            wait_idle(ok);
            if (!ok) begin
                total_cnt++;
                $display("FAIL key_%h_idle_timeout busy=%b exp=0", k, busy);
            end
        end
    endtask

    task automatic test_invalid_cols();
        logic [3:0] bad_cols [3];
        bit ok;
        bad_cols[0] = 4'b1111; bad_cols[1] = 4'b0000; bad_cols[2] = 4'b1100;
        key_in = 4'hD; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_pressed(ok);
        Col = 4'b1110;
        tick(); tick();
        total_cnt++;
        if (!ok || Row !== 4'b1110) $display("FAIL keyD_row ok=%0d got=%b exp=1110", ok, Row); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            Col = bad_cols[i];
            tick(); tick();
            total_cnt++;
            if (Row !== 4'hF) $display("FAIL invalid_col col=%b got=%b exp=1111", bad_cols[i], Row);
            else pass_cnt++;
        end
        Col = 4'hF;
        wait_idle(ok);
        total_cnt++; if (!ok) $display("FAIL invalid_idle_timeout busy=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [6];
        int drop_at, rise, fall, last_fall, accepted;
        bit acc, ok;
        logic [7:0] m;
        seq[0] = 4'h3; seq[1] = 4'hA; seq[2] = 4'h0;
        seq[3] = 4'hF; seq[4] = 4'h7; seq[5] = 4'hC;
        drop_at = -1; last_fall = -1; accepted = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    key_in = seq[i]; key_valid = 1'b1;
                    for (int w = 0; w < 200; w++) begin
                        acc = key_ready;
                        if (!key_ready && drop_at < 0) drop_at = i;
                        tick();
                        if (acc) begin
                            accepted++;
                            break;
                        end
                    end
                end
                key_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    wait_pressed(ok);
                    rise = cyc;
                    if (i > 0) begin
                        total_cnt++;
                        if (rise - last_fall != G + 1)
                            $display("FAIL b2b_gap_%0d got=%0d exp=%0d", i, rise - last_fall, G + 1);
                        else pass_cnt++;
                    end
                    m = exp_map(seq[i]);
                    Col = m[7:4];
                    tick(); tick();
                    total_cnt++;
                    if (!ok || Row !== m[3:0])
                        $display("FAIL b2b_order_%0d key=%h got=%b exp=%b", i, seq[i], Row, m[3:0]);
                    else pass_cnt++;
                    Col = 4'hF;
                    wait_released(ok);
                    fall = cyc;
                    total_cnt++;
                    if (!ok || fall - rise != H)
                        $display("FAIL b2b_hold_%0d got=%0d exp=%0d", i, fall - rise, H);
                    else pass_cnt++;
                    last_fall = fall;
                end
            end
        join
        total_cnt++; if (drop_at != 5) $display("FAIL b2b_ready_drop got=%0d exp=5", drop_at); else pass_cnt++;
        total_cnt++; if (accepted != 6) $display("FAIL b2b_accepted got=%0d exp=6", accepted); else pass_cnt++;
        wait_idle(ok);
        total_cnt++; if (!ok) $display("FAIL b2b_idle_timeout busy=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int seen;
        bit ok;
        key_valid = 1'b1;
        key_in = 4'h9; tick();
        key_in = 4'h1; tick();
        key_in = 4'h2; tick();
        key_valid = 1'b0;
        wait_pressed(ok);
        Col = 4'b1101;
        tick(); tick();
        total_cnt++;
        if (!ok || Row !== 4'b1101) $display("FAIL midrst_pre_row ok=%0d got=%b exp=1101", ok, Row); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (Row !== 4'hF) $display("FAIL midrst_row got=%b exp=1111", Row); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (pressed !== 1'b0) $display("FAIL midrst_pressed got=%b exp=0", pressed); else pass_cnt++;
        total_cnt++; if (key_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", key_ready); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pressed !== 1'b0 || busy !== 1'b0 || Row !== 4'hF) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL midrst_no_press got=%0d active cycles exp=0", seen); else pass_cnt++;
        Col = 4'hF;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_all_keys();
        test_invalid_cols();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
